btf_lane_array: RTL and testbench
=================================

BTF_LANE_ARRAY -- requirements
Module: btf_lane_array

Interface
REQ-001 SHALL have parameter LOGQ, default 32: coefficient/modulus width in bits.
REQ-002 SHALL have parameter NLANE, default 4: number of parallel butterfly lanes.
REQ-003 SHALL have parameter IS_Q_FIXED, default 0: 1 = use parameter Q, ignore port q.
REQ-004 SHALL have parameter Q, default 0: fixed odd modulus, used when IS_Q_FIXED=1.
REQ-005 SHALL have parameters DELAY_ADD, DELAY_MUL, DELAY_RED, DELAY_DIV2, all default 1, all >=1: per-stage pipeline depths.
REQ-006 SHALL have the following ports; one clock, reset synchronous active-high:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  beat accepted when in_valid&in_ready
- in_gs  in  1  0 = Cooley-Tukey (CT), 1 = Gentleman-Sande (GS)
- in_div2  in  1  halve both outputs mod q (INTT scaling)
- in_a  in  NLANE*LOGQ  lane-packed operand a, lane 0 in LSBs
- in_b  in  NLANE*LOGQ  lane-packed operand b
- in_w  in  NLANE*LOGQ  lane-packed twiddle
- q  in  LOGQ  modulus (odd, >2), static while busy=1
- out_valid  out  1  result beat valid
- out_a  out  NLANE*LOGQ  lane-packed result a
- out_b  out  NLANE*LOGQ  lane-packed result b
- busy  out  1  one or more beats in flight

Function
REQ-007 Per lane, CT SHALL produce out_a=(a+b*w) mod q and out_b=(a-b*w) mod q.
REQ-008 Per lane, GS SHALL produce out_a=(a+b) mod q and out_b=((a-b)*w) mod q.
REQ-009 Inputs SHALL satisfy a,b,w<q; all results SHALL lie in [0,q-1].
REQ-010 Div2 SHALL map x to x>>1 if x even, else (x+q)>>1, using LOGQ+1-bit intermediates.
REQ-011 Latency SHALL be LAT=DELAY_ADD+DELAY_MUL+DELAY_RED+DELAY_DIV2 cycles from accept to out_valid, identical for CT, GS, div2 on/off.
REQ-012 With in_div2=0, the div2 stage SHALL pass data through unchanged and still add DELAY_DIV2 cycles.
REQ-013 The block SHALL accept one beat per cycle; the output has no backpressure.
REQ-014 in_gs and in_div2 SHALL be captured per beat and travel with that beat's valid tag.
REQ-015 The arithmetic units are shared between modes, so the block SHALL keep a mode register (CT/GS) with two states: IDLE (in-flight count 0) and RUN (count >0).
REQ-016 While in RUN, a valid beat whose in_gs differs from the mode register SHALL see in_ready=0 until the pipeline drains; the mode register SHALL update when the beat is accepted.
REQ-017 in_ready SHALL be 1 in IDLE and for same-mode beats; in_ready SHALL NOT depend combinationally on in_a, in_b or in_w.
REQ-018 The in-flight counter (0..LAT) SHALL increment on accept, decrement on out_valid, and hold when both occur in the same cycle.
REQ-019 busy SHALL equal (count!=0).
REQ-020 out_a and out_b SHALL be 0 whenever out_valid=0.

Reset
REQ-021 rst SHALL clear the valid/mode tag pipeline, the in-flight counter and the mode register (CT), forcing out_valid=0, out_a=0, out_b=0, busy=0 and in_ready=1 on the next cycle.
REQ-022 Beats in flight when rst asserts SHALL be discarded and SHALL never produce out_valid.
REQ-023 Datapath registers are not required to be reset.

Structure
REQ-024 A shared package SHALL hold the mode encodings (MODE_CT=0, MODE_GS=1) and a function computing LAT.
REQ-025 One sub-module, btf_lane (a single-lane data-only butterfly with a div2 stage), SHALL be instantiated NLANE times; control SHALL be common to all lanes.

Verification
REQ-026 q=7681, CT: a=5, b=3, w=2 -> out_a=11, out_b=7680 after exactly LAT cycles.
REQ-027 q=7681, GS: a=5, b=3, w=2 -> out_a=8, out_b=4; same operands with div2 -> out_a=4, out_b=2.
REQ-028 q=7681, CT with div2: a=5, b=3, w=2 -> out_a=3846, out_b=3840.
REQ-029 10 back-to-back CT beats then 1 GS beat -> GS in_ready=0 until the last CT out_valid; no bubble inside the CT burst; 11 correct results.
REQ-030 rst asserted with 3 beats in flight -> no out_valid for those beats; busy=0 and in_ready=1 on the next cycle; the next beat completes correctly after LAT cycles.
REQ-031 NLANE=4 with distinct operands per lane, 1000 random beats of mixed mode and div2 vs reference model -> zero mismatches, lane order preserved.

Source files
------------

// File: rtl/btf_lane_array_pkg.sv
// ---------------------------------------------------------------
// btf_lane_array_pkg : mode encodings and latency helper
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package btf_lane_array_pkg;

  typedef enum logic {
    MODE_CT = 1'b0,
    MODE_GS = 1'b1
  } mode_e;

  function automatic int calc_lat(input int d_add, input int d_mul,
                                  input int d_red, input int d_div2);
    return d_add + d_mul + d_red + d_div2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btf_lane_array_lane.sv
// ---------------------------------------------------------------
// btf_lane : single-lane CT/GS modular butterfly with div2 stage
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module btf_lane
  import btf_lane_array_pkg::*;
#(
  parameter int LOGQ       = 32,
  parameter int DELAY_ADD  = 1,
  parameter int DELAY_MUL  = 1,
  parameter int DELAY_RED  = 1,
  parameter int DELAY_DIV2 = 1
) (
  input  logic            clk,
  input  logic            gs,
  input  logic            div2,
  input  logic [LOGQ-1:0] a,
  input  logic [LOGQ-1:0] b,
  input  logic [LOGQ-1:0] w,
  input  logic [LOGQ-1:0] q,
  output logic [LOGQ-1:0] out_a,
  output logic [LOGQ-1:0] out_b
);

  typedef struct packed {
    logic            gs;
    logic            div2;
    logic [LOGQ-1:0] x;
    logic [LOGQ-1:0] y;
    logic [LOGQ-1:0] w;
  } add_t;

  typedef struct packed {
    logic              gs;
    logic              div2;
    logic [LOGQ-1:0]   x;
    logic [2*LOGQ-1:0] p;
  } mul_t;

  typedef struct packed {
    logic            div2;
    logic [LOGQ-1:0] ra;
    logic [LOGQ-1:0] rb;
  } red_t;

  typedef struct packed {
    logic [LOGQ-1:0] a;
    logic [LOGQ-1:0] b;
  } div_t;

  // Both operands are already < m, so every sum/difference stays within LOGQ bits.
  function automatic logic [LOGQ-1:0] mod_add(input logic [LOGQ-1:0] x,
                                              input logic [LOGQ-1:0] y,
                                              input logic [LOGQ-1:0] m);
    logic [LOGQ-1:0] gap;
    gap = m - y;
    return (x >= gap) ? (x - gap) : (x + y);
  endfunction

  function automatic logic [LOGQ-1:0] mod_sub(input logic [LOGQ-1:0] x,
                                              input logic [LOGQ-1:0] y,
                                              input logic [LOGQ-1:0] m);
    return (x >= y) ? (x - y) : (x + (m - y));
  endfunction

  function automatic logic [LOGQ-1:0] half(input logic [LOGQ-1:0] x,
                                           input logic [LOGQ-1:0] m);
    return x[0] ? LOGQ'(({1'b0, x} + {1'b0, m}) >> 1) : (x >> 1);
  endfunction

  add_t add_in, add_pipe [DELAY_ADD];
  mul_t mul_in, mul_pipe [DELAY_MUL];
  red_t red_in, red_pipe [DELAY_RED];
  div_t div_in, div_pipe [DELAY_DIV2];
  logic [LOGQ-1:0] r;

  // GS does its add/sub up front; CT defers the add/sub until after reduction.
  always_comb begin
    add_in      = '0;
    add_in.gs   = gs;
    add_in.div2 = div2;
    add_in.w    = w;
    if (gs == MODE_GS) begin
      add_in.x = mod_add(a, b, q);
      add_in.y = mod_sub(a, b, q);
    end else begin
      add_in.x = a;
      add_in.y = b;
    end
  end

  always_comb begin
    mul_in      = '0;
    mul_in.gs   = add_pipe[DELAY_ADD-1].gs;
    mul_in.div2 = add_pipe[DELAY_ADD-1].div2;
    mul_in.x    = add_pipe[DELAY_ADD-1].x;
    mul_in.p    = (2*LOGQ)'(add_pipe[DELAY_ADD-1].y) * (2*LOGQ)'(add_pipe[DELAY_ADD-1].w);
  end

  always_comb begin
    r           = LOGQ'(mul_pipe[DELAY_MUL-1].p % (2*LOGQ)'(q));
    red_in      = '0;
    red_in.div2 = mul_pipe[DELAY_MUL-1].div2;
    if (mul_pipe[DELAY_MUL-1].gs == MODE_GS) begin
      red_in.ra = mul_pipe[DELAY_MUL-1].x;
      red_in.rb = r;
    end else begin
      red_in.ra = mod_add(mul_pipe[DELAY_MUL-1].x, r, q);
      red_in.rb = mod_sub(mul_pipe[DELAY_MUL-1].x, r, q);
    end
  end

  always_comb begin
    div_in = '0;
    if (red_pipe[DELAY_RED-1].div2) begin
      div_in.a = half(red_pipe[DELAY_RED-1].ra, q);
      div_in.b = half(red_pipe[DELAY_RED-1].rb, q);
    end else begin
      div_in.a = red_pipe[DELAY_RED-1].ra;
      div_in.b = red_pipe[DELAY_RED-1].rb;
    end
  end

  always_ff @(posedge clk) begin
    add_pipe[0] <= add_in;
    for (int i = 1; i < DELAY_ADD; i++) add_pipe[i] <= add_pipe[i-1];
    mul_pipe[0] <= mul_in;
    for (int i = 1; i < DELAY_MUL; i++) mul_pipe[i] <= mul_pipe[i-1];
    red_pipe[0] <= red_in;
    for (int i = 1; i < DELAY_RED; i++) red_pipe[i] <= red_pipe[i-1];
    div_pipe[0] <= div_in;
    for (int i = 1; i < DELAY_DIV2; i++) div_pipe[i] <= div_pipe[i-1];
  end

  assign out_a = div_pipe[DELAY_DIV2-1].a;
  assign out_b = div_pipe[DELAY_DIV2-1].b;

endmodule

`default_nettype wire

// File: rtl/btf_lane_array.sv
// ---------------------------------------------------------------
// btf_lane_array : NLANE parallel butterflies with shared mode control
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module btf_lane_array
  import btf_lane_array_pkg::*;
#(
  parameter int              LOGQ       = 32,
  parameter int              NLANE      = 4,
  parameter int              IS_Q_FIXED = 0,
  parameter logic [LOGQ-1:0] Q          = '0,
  parameter int              DELAY_ADD  = 1,
  parameter int              DELAY_MUL  = 1,
  parameter int              DELAY_RED  = 1,
  parameter int              DELAY_DIV2 = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_gs,
  input  logic                  in_div2,
  input  logic [NLANE*LOGQ-1:0] in_a,
  input  logic [NLANE*LOGQ-1:0] in_b,
  input  logic [NLANE*LOGQ-1:0] in_w,
  input  logic [LOGQ-1:0]       q,
  output logic                  out_valid,
  output logic [NLANE*LOGQ-1:0] out_a,
  output logic [NLANE*LOGQ-1:0] out_b,
  output logic                  busy
);

  localparam int LAT = calc_lat(DELAY_ADD, DELAY_MUL, DELAY_RED, DELAY_DIV2);
  localparam int CW  = $clog2(LAT + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state, state_nxt;
  mode_e                 mode;
  logic [CW-1:0]         count, count_nxt;
  logic [LAT-1:0]        vld;
  logic                  accept;
  logic [LOGQ-1:0]       q_eff;
  logic [NLANE*LOGQ-1:0] lane_a, lane_b;

  assign q_eff     = (IS_Q_FIXED != 0) ? Q : q;
  assign accept    = in_valid & in_ready;
  assign out_valid = vld[LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      mode  <= MODE_CT;
      count <= '0;
      vld   <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      vld   <= {vld[LAT-2:0], accept};
      if (accept) mode <= mode_e'(in_gs);
    end
  end

  always_comb begin
    count_nxt = count;
    case ({accept, out_valid})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
    state_nxt = (count_nxt != '0) ? ST_RUN : ST_IDLE;
  end

  // A mode switch must wait for the shared pipeline to drain.
  always_comb begin
    in_ready = (state == ST_IDLE) || (mode == mode_e'(in_gs));
    busy     = (count != '0);
  end

  for (genvar l = 0; l < NLANE; l++) begin : g_lane
    btf_lane #(
      .LOGQ      (LOGQ),
      .DELAY_ADD (DELAY_ADD),
      .DELAY_MUL (DELAY_MUL),
      .DELAY_RED (DELAY_RED),
      .DELAY_DIV2(DELAY_DIV2)
    ) u_lane (
      .clk  (clk),
      .gs   (in_gs),
      .div2 (in_div2),
      .a    (in_a[l*LOGQ +: LOGQ]),
      .b    (in_b[l*LOGQ +: LOGQ]),
      .w    (in_w[l*LOGQ +: LOGQ]),
      .q    (q_eff),
      .out_a(lane_a[l*LOGQ +: LOGQ]),
      .out_b(lane_b[l*LOGQ +: LOGQ])
    );
  end

  assign out_a = out_valid ? lane_a : '0;
  assign out_b = out_valid ? lane_b : '0;

endmodule

`default_nettype wire

// File: tb/tb_btf_lane_array.sv
// ---------------------------------------------------------------
// tb_btf_lane_array : directed + reference-model bench for btf_lane_array
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_btf_lane_array;

  localparam int LOGQ  = 32;
  localparam int NLANE = 4;
  localparam int W     = NLANE * LOGQ;
  localparam int LAT   = 5;           // 1 + 2 + 1 + 1
  localparam int QV    = 7681;
  localparam int NRND  = 1000;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, in_gs, in_div2, out_valid, busy;
  logic [W-1:0] in_a, in_b, in_w, out_a, out_b;
  logic [31:0]  q;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;
  exp_t exp_q[$];

  logic         s_gs   [NRND];
  logic         s_div2 [NRND];
  logic [W-1:0] s_a    [NRND];
  logic [W-1:0] s_b    [NRND];
  logic [W-1:0] s_w    [NRND];
  int           acc_cyc[NRND];

  btf_lane_array #(
    .LOGQ(LOGQ), .NLANE(NLANE), .IS_Q_FIXED(0), .Q(32'd0),
    .DELAY_ADD(1), .DELAY_MUL(2), .DELAY_RED(1), .DELAY_DIV2(1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_gs(in_gs), .in_div2(in_div2), .in_a(in_a), .in_b(in_b), .in_w(in_w),
    .q(q), .out_valid(out_valid), .out_a(out_a), .out_b(out_b), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint half_ref(input longint x);
    return (x % 2 == 1) ? (x + QV) / 2 : x / 2;
  endfunction

  function automatic logic [63:0] ref_bf(input logic gs, input logic div2,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] w);
    longint la, lb, lw, t, oa, ob;
    la = longint'(a); lb = longint'(b); lw = longint'(w);
    if (gs) begin
      oa = (la + lb) % QV;
      ob = (((la - lb + QV) % QV) * lw) % QV;
    end else begin
      t  = (lb * lw) % QV;
      oa = (la + t) % QV;
      ob = (la - t + QV) % QV;
    end
    if (div2) begin
      oa = half_ref(oa);
      ob = half_ref(ob);
    end
    return {32'(oa), 32'(ob)};
  endfunction

  // One beat with every lane identical; checks latency cycle by cycle.
  task automatic run_one(input string tag, input logic gs, input logic div2,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                         input logic [31:0] ea, input logic [31:0] eb);
    in_valid = 1'b1; in_gs = gs; in_div2 = div2;
    in_a = {NLANE{a}}; in_b = {NLANE{b}}; in_w = {NLANE{w}};
    @(negedge clk);
    chk1({tag, ".ready"}, in_ready, 1'b1);
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk1({tag, ".valid"}, out_valid, (i == LAT));
      if (i == 1) chk1({tag, ".busy"}, busy, 1'b1);
      if (i == LAT) begin
        chkw({tag, ".out_a"}, out_a, {NLANE{ea}});
        chkw({tag, ".out_b"}, out_b, {NLANE{eb}});
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk1({tag, ".idle_busy"}, busy, 1'b0);
    chkw({tag, ".idle_a"}, out_a, '0);
    @(posedge clk); #1;
  endtask

  task automatic run_stream(input int n, input int max_cyc, output int stalls);
    int idx, cyc;
    exp_t e;
    logic [63:0] r;
    idx = 0; cyc = 0; stalls = 0;
    while ((idx < n || exp_q.size() != 0) && cyc < max_cyc) begin
      if (idx < n) begin
        in_valid = 1'b1; in_gs = s_gs[idx]; in_div2 = s_div2[idx];
        in_a = s_a[idx]; in_b = s_b[idx]; in_w = s_w[idx];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) chk1("stream.spurious", out_valid, 1'b0);
        else begin
          e = exp_q.pop_front();
          chkw("stream.out_a", out_a, e.a);
          chkw("stream.out_b", out_b, e.b);
        end
      end else begin
        chkw("stream.zero_a", out_a, '0);
        chkw("stream.zero_b", out_b, '0);
      end
      if (in_valid && in_ready) begin
        for (int l = 0; l < NLANE; l++) begin
          r = ref_bf(s_gs[idx], s_div2[idx], s_a[idx][l*32 +: 32],
                     s_b[idx][l*32 +: 32], s_w[idx][l*32 +: 32]);
          e.a[l*32 +: 32] = r[63:32];
          e.b[l*32 +: 32] = r[31:0];
        end
        exp_q.push_back(e);
        acc_cyc[idx] = cyc;
        idx++;
      end else if (in_valid) begin
        stalls++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk1("stream.done", (idx == n && exp_q.size() == 0), 1'b1);
    exp_q.delete();
  endtask

  initial begin
    int stalls;
    logic g;
    rst = 1'b1; in_valid = 1'b0; in_gs = 1'b0; in_div2 = 1'b0;
    in_a = '0; in_b = '0; in_w = '0; q = 32'(QV);

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    chk1("rst.out_valid", out_valid, 1'b0);
    chk1("rst.busy", busy, 1'b0);
    chk1("rst.in_ready", in_ready, 1'b1);
    chkw("rst.out_a", out_a, '0);
    chkw("rst.out_b", out_b, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors, hand-computed for q=7681
    run_one("ct",       1'b0, 1'b0, 32'd5, 32'd3, 32'd2, 32'd11,   32'd7680);
    run_one("gs",       1'b1, 1'b0, 32'd5, 32'd3, 32'd2, 32'd8,    32'd4);
    run_one("gs_div2",  1'b1, 1'b1, 32'd5, 32'd3, 32'd2, 32'd4,    32'd2);
    run_one("ct_div2",  1'b0, 1'b1, 32'd5, 32'd3, 32'd2, 32'd3846, 32'd3840);
    run_one("ct_max",   1'b0, 1'b0, 32'd7680, 32'd7680, 32'd7680, 32'd0, 32'd7679);
    run_one("gs_max",   1'b1, 1'b0, 32'd0, 32'd7680, 32'd7680, 32'd7680, 32'd7680);

    // 10 CT beats back to back, then one GS beat that must wait for the drain
    for (int i = 0; i < 11; i++) begin
      s_gs[i] = (i == 10); s_div2[i] = i[0];
      for (int l = 0; l < NLANE; l++) begin
        s_a[i][l*32 +: 32] = 32'(100 * i + l);
        s_b[i][l*32 +: 32] = 32'(7000 - 13 * i - l);
        s_w[i][l*32 +: 32] = 32'(17 + l + i);
      end
    end
    run_stream(11, 200, stalls);
    chki("burst.ct_last_accept", acc_cyc[9], 9);
    chki("burst.gs_accept", acc_cyc[10], 10 + LAT);
    chki("burst.stalls", stalls, LAT);

    // Reset with 3 beats in flight
    in_valid = 1'b1; in_gs = 1'b0; in_div2 = 1'b0;
    in_a = {NLANE{32'd5}}; in_b = {NLANE{32'd3}}; in_w = {NLANE{32'd2}};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("flush.ready", in_ready, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk1("flush.busy_before", busy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("flush.busy", busy, 1'b0);
    chk1("flush.in_ready", in_ready, 1'b1);
    chk1("flush.out_valid", out_valid, 1'b0);
    for (int i = 0; i < LAT + 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk1("flush.no_valid", out_valid, 1'b0);
    end
    @(posedge clk); #1;
    run_one("post_flush", 1'b0, 1'b0, 32'd5, 32'd3, 32'd2, 32'd11, 32'd7680);

    // Random mixed-mode stream against the reference model
    g = 1'b0;
    for (int i = 0; i < NRND; i++) begin
      if ($urandom_range(3) == 0) g = ~g;
      s_gs[i] = g;
      s_div2[i] = 1'($urandom_range(1));
      for (int l = 0; l < NLANE; l++) begin
        s_a[i][l*32 +: 32] = $urandom_range(QV - 1);
        s_b[i][l*32 +: 32] = $urandom_range(QV - 1);
        s_w[i][l*32 +: 32] = $urandom_range(QV - 1);
      end
    end
    run_stream(NRND, NRND * (LAT + 2) + 100, stalls);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
